// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg
// Shared definitions for the framed serial transmitter:
//   state_e - frame FSM states (IDLE, START, DATA, PARITY, STOP)
//   cnt_w   - width helper for counters that must hold 0..n-1
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one bit so that
  // degenerate parameter values still give a legal vector.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer
// Counts CLKS_PER_BIT clock cycles per serial bit and wraps to 0.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset (clears the count)
//   clr     in  synchronous clear, asserted when a frame starts
//   en      in  count enable (frame in progress)
//   tc      out count is at CLKS_PER_BIT-1 this cycle
//   tc_next out count will be at CLKS_PER_BIT-1 next cycle
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic tc_next
);

  localparam int CNT_W = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc      = (cnt_q == LAST);
  // Look-ahead lets the parent register a flag that is valid exactly in
  // the terminal cycle rather than one cycle late.
  assign tc_next = !rst && (cnt_d == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Framed serial transmitter: start bit (0), DATA_W data bits LSB first,
// optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT
// cycles. tx, busy and done are flop outputs.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   data_in in  payload, captured on an accepted load
//   load    in  request to send data_in
//   ready   out load will be accepted this cycle
//   tx      out serial line, idle high
//   busy    out frame in progress
//   done    out pulse in the final cycle of the stop bit
module serial_frame_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = cnt_w(DATA_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic tc;
  logic tc_next;
  logic accept;

  // Ready comes from registered state only; STOP's terminal cycle is
  // included so frames can run back to back with no idle gap.
  assign ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tc));
  assign accept = load && ready;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (busy_q),
    .tc     (tc),
    .tc_next(tc_next)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    tx_d      = tx_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
      end
      ST_START: begin
        if (tc) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tc) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shift_d[0];
          end
        end
      end
      ST_PARITY: begin
        if (tc) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tc) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Accept is only possible in IDLE or the last STOP cycle, so it
    // simply overrides whatever the state decode chose above.
    if (accept) begin
      shift_d   = data_in;
      parity_d  = ^data_in;
      bit_idx_d = '0;
      state_d   = ST_START;
      tx_d      = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && tc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // dut0: defaults (8 bits, 4 clk/bit, parity)
  logic [7:0] d0;
  logic       l0, r0, t0, b0, dn0;
  // dut1: no parity
  logic [7:0] d1;
  logic       l1, r1, t1, b1, dn1;
  // dut2: 1 data bit, 2 clk/bit, parity
  logic [0:0] d2;
  logic       l2, r2, t2, b2, dn2;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .clk(clk), .rst(rst), .data_in(d0), .load(l0),
    .ready(r0), .tx(t0), .busy(b0), .done(dn0)
  );

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .data_in(d1), .load(l1),
    .ready(r1), .tx(t1), .busy(b1), .done(dn1)
  );

  serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(2), .PARITY_EN(1)) dut2 (
    .clk(clk), .rst(rst), .data_in(d2), .load(l2),
    .ready(r2), .tx(t2), .busy(b2), .done(dn2)
  );

  task automatic test_reset();
    rst = 1'b1;
    d0 = 8'hFF; l0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (t0 !== 1'b1) $display("FAIL reset_tx got=%b exp=1", t0); else pass_cnt++;
    total_cnt++; if (b0 !== 1'b0) $display("FAIL reset_busy got=%b exp=0", b0); else pass_cnt++;
    total_cnt++; if (dn0 !== 1'b0) $display("FAIL reset_done got=%b exp=0", dn0); else pass_cnt++;
    total_cnt++; if (r0 !== 1'b0) $display("FAIL reset_ready got=%b exp=0", r0); else pass_cnt++;
    l0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (r0 !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", r0); else pass_cnt++;
    total_cnt++; if (b0 !== 1'b0) $display("FAIL reset_load_discarded busy got=%b exp=0", b0); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_frame_a5();
    string s = "01010010101";
    int dones = 0;
    @(negedge clk);
    d0 = 8'hA5; l0 = 1'b1;
    total_cnt++; if (r0 !== 1'b1) $display("FAIL a5_ready_idle got=%b exp=1", r0); else pass_cnt++;
    @(posedge clk); #1 l0 = 1'b0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      total_cnt++; if (t0 !== (s[c/4] == "1")) $display("FAIL a5_tx cyc=%0d got=%b exp=%s", c+1, t0, s.substr(c/4, c/4)); else pass_cnt++;
      total_cnt++; if (dn0 !== (c == 43)) $display("FAIL a5_done cyc=%0d got=%b", c+1, dn0); else pass_cnt++;
      total_cnt++; if (b0 !== 1'b1) $display("FAIL a5_busy cyc=%0d got=%b exp=1", c+1, b0); else pass_cnt++;
      if (dn0 === 1'b1) dones++;
    end
    @(negedge clk);
    total_cnt++; if (t0 !== 1'b1) $display("FAIL a5_tx_idle got=%b exp=1", t0); else pass_cnt++;
    total_cnt++; if (b0 !== 1'b0) $display("FAIL a5_busy_end got=%b exp=0", b0); else pass_cnt++;
    total_cnt++; if (dones !== 1) $display("FAIL a5_done_count got=%0d exp=1", dones); else pass_cnt++;
    $display("test_frame_a5 done");
  endtask

  task automatic test_no_parity();
    string s = "0111000001";
    @(negedge clk);
    d1 = 8'h07; l1 = 1'b1;
    @(posedge clk); #1 l1 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      total_cnt++; if (t1 !== (s[c/4] == "1")) $display("FAIL nopar_tx cyc=%0d got=%b exp=%s", c+1, t1, s.substr(c/4, c/4)); else pass_cnt++;
      total_cnt++; if (dn1 !== (c == 39)) $display("FAIL nopar_done cyc=%0d got=%b", c+1, dn1); else pass_cnt++;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total_cnt++; if (t1 !== 1'b1) $display("FAIL nopar_tx_after cyc=%0d got=%b exp=1", c, t1); else pass_cnt++;
      total_cnt++; if (b1 !== 1'b0) $display("FAIL nopar_busy_after cyc=%0d got=%b exp=0", c, b1); else pass_cnt++;
    end
    $display("test_no_parity done");
  endtask

  task automatic test_back_to_back();
    string s = "0100000001100000000111";
    @(negedge clk);
    d0 = 8'h01; l0 = 1'b1;
    @(posedge clk); #1 d0 = 8'h80;
    for (int c = 0; c < 88; c++) begin
      @(negedge clk);
      total_cnt++; if (t0 !== (s[c/4] == "1")) $display("FAIL b2b_tx cyc=%0d got=%b exp=%s", c+1, t0, s.substr(c/4, c/4)); else pass_cnt++;
      total_cnt++; if (dn0 !== (c == 43 || c == 87)) $display("FAIL b2b_done cyc=%0d got=%b", c+1, dn0); else pass_cnt++;
      total_cnt++; if (b0 !== 1'b1) $display("FAIL b2b_busy cyc=%0d got=%b exp=1", c+1, b0); else pass_cnt++;
      if (c == 43) begin
        total_cnt++; if (r0 !== 1'b1) $display("FAIL b2b_ready_stop got=%b exp=1", r0); else pass_cnt++;
      end
      if (c == 87) l0 = 1'b0;
    end
    @(negedge clk);
    total_cnt++; if (b0 !== 1'b0) $display("FAIL b2b_busy_end got=%b exp=0", b0); else pass_cnt++;
    $display("test_back_to_back done");
  endtask

  task automatic test_load_ignored();
    string s = "01010010101";
    @(negedge clk);
    d0 = 8'hA5; l0 = 1'b1;
    @(posedge clk); #1 l0 = 1'b0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      total_cnt++; if (t0 !== (s[c/4] == "1")) $display("FAIL ign_tx cyc=%0d got=%b exp=%s", c+1, t0, s.substr(c/4, c/4)); else pass_cnt++;
      if (c == 10) begin
        total_cnt++; if (r0 !== 1'b0) $display("FAIL ign_ready_busy got=%b exp=0", r0); else pass_cnt++;
        d0 = 8'hFF; l0 = 1'b1;
      end
      if (c == 11) l0 = 1'b0;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total_cnt++; if (b0 !== 1'b0) $display("FAIL ign_no_second_frame cyc=%0d busy=%b exp=0", c, b0); else pass_cnt++;
      total_cnt++; if (t0 !== 1'b1) $display("FAIL ign_tx_idle cyc=%0d got=%b exp=1", c, t0); else pass_cnt++;
    end
    $display("test_load_ignored done");
  endtask

  task automatic test_reset_midframe();
    string s = "00011110001";
    @(negedge clk);
    d0 = 8'hA5; l0 = 1'b1;
    @(posedge clk); #1 l0 = 1'b0;
    // frame cycles 17..20 carry data bit 3; assert reset inside it
    for (int c = 0; c < 17; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (t0 !== 1'b1) $display("FAIL midrst_tx got=%b exp=1", t0); else pass_cnt++;
    total_cnt++; if (b0 !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", b0); else pass_cnt++;
    total_cnt++; if (r0 !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", r0); else pass_cnt++;
    total_cnt++; if (dn0 !== 1'b0) $display("FAIL midrst_done got=%b exp=0", dn0); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++; if (r0 !== 1'b1) $display("FAIL midrst_ready_after got=%b exp=1", r0); else pass_cnt++;
    total_cnt++; if (dn0 !== 1'b0) $display("FAIL midrst_done_after got=%b exp=0", dn0); else pass_cnt++;
    d0 = 8'h3C; l0 = 1'b1;
    @(posedge clk); #1 l0 = 1'b0;
    for (int c = 0; c < 44; c++) begin
      @(negedge clk);
      total_cnt++; if (t0 !== (s[c/4] == "1")) $display("FAIL x3c_tx cyc=%0d got=%b exp=%s", c+1, t0, s.substr(c/4, c/4)); else pass_cnt++;
      total_cnt++; if (dn0 !== (c == 43)) $display("FAIL x3c_done cyc=%0d got=%b", c+1, dn0); else pass_cnt++;
    end
    $display("test_reset_midframe done");
  endtask

  task automatic test_small();
    string s = "0111";
    @(negedge clk);
    d2 = 1'b1; l2 = 1'b1;
    @(posedge clk); #1 l2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total_cnt++; if (t2 !== (s[c/2] == "1")) $display("FAIL small_tx cyc=%0d got=%b exp=%s", c+1, t2, s.substr(c/2, c/2)); else pass_cnt++;
      total_cnt++; if (dn2 !== (c == 7)) $display("FAIL small_done cyc=%0d got=%b", c+1, dn2); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++; if (b2 !== 1'b0) $display("FAIL small_busy_end got=%b exp=0", b2); else pass_cnt++;
    total_cnt++; if (r2 !== 1'b1) $display("FAIL small_ready_end got=%b exp=1", r2); else pass_cnt++;
    $display("test_small done");
  endtask

  initial begin
    rst = 1'b1;
    d0 = '0; l0 = 1'b0;
    d1 = '0; l1 = 1'b0;
    d2 = '0; l2 = 1'b0;
    test_reset();
    test_frame_a5();
    test_no_parity();
    test_back_to_back();
    test_load_ignored();
    test_reset_midframe();
    test_small();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Framed serial transmitter that serialises one parallel word per accepted load into a start/data/parity/stop bit stream on a single output line. It is the driving end of the serial-capture test designs: its `tx` line feeds a receiver's registered capture path in the same netlist test suite, so every output is a flop output. It also gives the timing flow a multi-state register-to-register design with a counter feedback loop.

## Interface
Parameters:
- `DATA_W`, 8: payload bits per frame, 1..16.
- `CLKS_PER_BIT`, 4: clock cycles each serial bit is held, 2..255.
- `PARITY_EN`, 1: 1 = append even-parity bit, 0 = no parity bit.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  DATA_W  payload, sampled only on an accepted load.
- `load`  in  1  request to send `data_in`.
- `ready`  out  1  block can accept `load` this cycle.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  frame in progress (START through STOP).
- `done`  out  1  one-cycle pulse in the final cycle of STOP.

## Operation
- Accept: `load && ready` at a rising edge. Copy `data_in` into the shift register. Compute parity as the XOR of all data bits. Go to START. `load` while `!ready` is ignored, with no queuing.
- States:
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=shift[0], LSB first, shift right once per bit.
  - PARITY: `tx`=parity. Skipped when `PARITY_EN`=0.
  - STOP: `tx`=1.
- Transitions: each of START, DATA, PARITY and STOP lasts exactly `CLKS_PER_BIT` cycles per bit. DATA lasts `DATA_W` bits, counted by a bit index. At the end of STOP, go to START if a load is accepted in that cycle, otherwise go to IDLE.
- `ready` = (state==IDLE) || (state==STOP && bit-timer at terminal count), gated low while `rst`=1. This allows back-to-back frames with no idle gap.
- `busy` = state != IDLE.
- `done` = STOP && terminal count.
- Frame length: (2 + `DATA_W` + `PARITY_EN`) × `CLKS_PER_BIT` cycles.
- Counter widths:
  - bit timer: $clog2(`CLKS_PER_BIT`) bits, counts 0..`CLKS_PER_BIT`-1 and wraps to 0.
  - bit index: $clog2(`DATA_W`+1) bits.
  - Neither counter may overflow at the maximum parameter values.
- Reset: takes effect at the next edge and overrides all other inputs. Result: IDLE, `tx`=1, `busy`=0, `done`=0, counters and shift register cleared, `ready`=0 while `rst` is high. A load presented during the reset cycle is discarded.
- Reset mid-frame: the frame is aborted and `tx` returns high at that edge. No `done` pulse is produced.

## Timing
- `tx`, `busy` and `done` are registered; there is no combinational path from inputs to them.
- `ready` is decoded from registered state (and `rst`) only, never from `load`.
- Load accepted at edge N: `tx` falls and `busy` rises at edge N, i.e. they are visible in cycle N+1.
- First data bit appears at edge N+`CLKS_PER_BIT`.
- `done` is high in the last cycle of the frame. The next frame's START begins on the following edge if `load` is high in that cycle.
- `ready` first rises in the cycle after `rst` deasserts.

## Structure
- Package `serial_tx_pkg`: state enum (IDLE, START, DATA, PARITY, STOP) and a localparam helper for counter widths.
- Sub-module `bit_timer`: counts `CLKS_PER_BIT` cycles, with synchronous clear on `rst` or on frame start. Outputs a terminal-count flag.
- Top level holds the FSM, shift register, bit index and parity flop.

## Test plan
- Defaults, load 0xA5 once:
  - `tx` = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB first, parity 0, stop), each bit held 4 cycles.
  - Frame is 44 cycles; `done` pulses once in cycle 44.
- `PARITY_EN`=0, load 0x07: 10 bits, 40 cycles, no parity slot, `tx` high after stop.
- Back-to-back: hold `load`=1 with 0x01 then 0x80. The second start bit immediately follows the first stop bit with zero idle cycles, and two `done` pulses are 44 cycles apart.
- Load pulsed mid-frame with 0xFF while `busy`: ignored, the frame in flight is unchanged, and no second frame is sent.
- `rst` asserted in DATA bit 3:
  - next cycle: `tx`=1, `busy`=0, `ready`=0, no `done`.
  - after release, `ready`=1 one cycle later, and a fresh load of 0x3C transmits correctly.
- `CLKS_PER_BIT`=2, `DATA_W`=1, load 1: `tx` = 0,1,1,1 with each bit held 2 cycles; 8-cycle frame; `done` in cycle 8.
